// File: rtl/mips_avalon_pkg.sv
// Shared types and default widths for the MIPS Avalon-MM master bridge.
package mips_avalon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int DEF_ADDR_WIDTH     = 32;
   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/mips_avalon_wait_counter.sv
// Saturating waitrequest-stall counter; expired flags the LIMIT-th consecutive stall cycle.
// Only instantiated when MIPS_AVALON_TIMEOUT_EN is defined.
module mips_avalon_wait_counter #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear)
         cnt <= '0;
      else if (count_en && cnt != LAST)
         cnt <= cnt + 1'b1;
   end

   // cnt holds the number of stalls already seen, so the current stall is the last allowed one
   assign expired = count_en && (cnt == LAST);

endmodule

// File: rtl/mips_avalon_master.sv
// Avalon-MM master bridge: one outstanding CPU request turned into a read/write honouring waitrequest.
// Optional stall timeout enabled by defining MIPS_AVALON_TIMEOUT_EN.
module mips_avalon_master
   import mips_avalon_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_byteen,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic [ADDR_WIDTH-1:0]   address,
   output logic                    read,
   output logic                    write,
   output logic [DATA_WIDTH-1:0]   writedata,
   output logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    waitrequest,
   input  logic [DATA_WIDTH-1:0]   readdata
);

   state_t state;
   logic   expired;

`ifdef MIPS_AVALON_TIMEOUT_EN
   logic err_q;

   mips_avalon_wait_counter #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_wait_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == IDLE),
      .count_en((state == RD || state == WR) && waitrequest),
      .expired (expired)
   );

   assign rsp_err = err_q;
`else
   assign expired = 1'b0;
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         read       <= 1'b0;
         write      <= 1'b0;
         address    <= '0;
         writedata  <= '0;
         byteenable <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
`ifdef MIPS_AVALON_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               rsp_valid <= 1'b0;
               if (req_valid) begin
                  address    <= req_addr;
                  writedata  <= req_wdata;
                  byteenable <= req_byteen;
                  read       <= !req_write;
                  write      <= req_write;
                  req_ready  <= 1'b0;
                  state      <= req_write ? WR : RD;
               end
            end
            RD, WR: begin
               if (!waitrequest) begin
                  read      <= 1'b0;
                  write     <= 1'b0;
                  rsp_valid <= 1'b1;
                  if (state == RD)
                     rsp_rdata <= readdata;
                  state     <= RESP;
               end else if (expired) begin
                  // abort: rsp_rdata deliberately left untouched
                  read      <= 1'b0;
                  write     <= 1'b0;
                  rsp_valid <= 1'b1;
`ifdef MIPS_AVALON_TIMEOUT_EN
                  err_q     <= 1'b1;
`endif
                  state     <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
`ifdef MIPS_AVALON_TIMEOUT_EN
               err_q     <= 1'b0;
`endif
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
